say_arbiter: RTL and testbench
==============================

# say_arbiter

Round-robin arbiter that shares one `say` request channel (a method/value pair of 192-bit operands) among `NREQ` requesters. It sits in front of the Connect block's `say` method. Grants rotate fairly among requesters that assert `want`. The accepted request is held in a one-entry output register, so downstream `say__RDY` never has a combinational path back to the requesters.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `DW`, default 192: width of each of `meth` and `v`.

Ports:
- `CLK`, in, 1: clock.
- `nRST`, in, 1: reset, synchronous, active-low (already decided).
- `req_want`, in, NREQ: level intent per requester. Must not depend on `req_RDY`.
- `req__ENA`, in, NREQ: fire strobe. Legal only while the matching `req_RDY` bit is 1.
- `req_meth`, in, NREQ*DW: per-requester method operand. Slice i is `[i*DW +: DW]`.
- `req_v`, in, NREQ*DW: per-requester value operand, packed the same way.
- `req_RDY`, out, NREQ: one-hot or zero grant-ready.
- `say__ENA`, out, 1: downstream fire.
- `say_meth`, out, DW: registered method operand.
- `say_v`, out, DW: registered value operand.
- `say__RDY`, in, 1: downstream ready. Independent of `say__ENA`.
- `say_src`, out, clog2(NREQ): index of the requester whose data is in the output register.
- `grant_count`, out, NREQ*16: only when `SAY_ARB_STATS_EN` is defined.

## Operation
- State:
  - `full`, 1 bit: the output register is occupied.
  - `last`: index of the most recent grant.
  - Output data registers and `say_src`.
- `can_accept = !full || say__RDY`.
- Grant selection:
  - `sel` is the first i with `req_want[i]`, searching cyclically from `last+1`.
  - `req_RDY = can_accept ? onehot(sel) : 0`.
  - `req_RDY` is 0 when no `want` bit is set.
- Accept: when `req__ENA[sel] && req_RDY[sel]`:
  - Latch slice `sel` of `meth` and `v`.
  - `say_src <= sel`, `last <= sel`, `full <= 1`.
- Drain: `say__ENA = full && say__RDY`.
  - Drain without accept in the same cycle: `full <= 0`.
  - Drain and accept in the same cycle: `full` stays 1 and the new data replaces the old.
- Protocol violations: an `ENA` bit on a non-granted requester, or with `req_RDY` = 0, is ignored. The register, `last` and the counters are unchanged.
- Fairness: a requester that holds `want` continuously is granted within NREQ accepts.

## Timing
- Reset values:
  - `full` = 0, so `say__ENA` = 0.
  - `say_meth` = 0, `say_v` = 0, `say_src` = 0.
  - `last` = NREQ-1, so requester 0 has first priority.
  - `grant_count` = 0.
- `req_RDY` may be 1 in the first cycle after reset if `want` is set.
- Latency: an accept in cycle t makes `say__ENA` possible in cycle t+1.
- Throughput: one request per cycle while `say__RDY` holds high.
- Backpressure: with `full` = 1 and `say__RDY` = 0, all `req_RDY` bits are 0 and data holds stable.
- Reset mid-operation: buffered data is discarded, with no `say__ENA` for it.
- Wrap-around: the search order after `last` = NREQ-1 is 0, 1, and so on.

## Configuration
- `SAY_ARB_STATS_EN` defined:
  - Per-requester 16-bit accept counters, exported on `grant_count`.
  - Each counter saturates at 16'hFFFF.
  - Counters clear on reset only.
- `SAY_ARB_STATS_EN` undefined: the counters and the `grant_count` port are absent. Arbitration behaviour is identical.

## Structure
- Shared package holds:
  - the `SAY_DW` constant (192);
  - the `SAY_ARB_MAX_NREQ` constant (8);
  - a `say_req_t` struct of `{meth, v}`.
- One sub-module, `rr_pick`: combinational cyclic priority encoder.
  - Inputs: `want`, `last`.
  - Outputs: `sel` and a `valid` flag.
  - Reusable by the rule scheduler.

## Test plan
- Reset then idle: all `want` bits 0 -> `req_RDY` = 0, `say__ENA` = 0, `say_meth` = 0 for 10 cycles.
- Contention, all four requesters want and fire, `say__RDY` = 1:
  - grant order is 0, 1, 2, 3, 0;
  - `say_src` follows one cycle later;
  - `meth` = 0x1 through 0x4 is passed through intact.
- Backpressure:
  - requester 2 fires `meth` = 0xABC while `say__RDY` = 0 -> `full` = 1 and `req_RDY` = 0 for 5 cycles, data stable;
  - `say__RDY` rises -> one `say__ENA`;
  - requester 3 is granted in the same cycle.
- Drain and accept in the same cycle: back-to-back fires with `say__RDY` = 1 -> exactly one `say__ENA` per cycle, no lost or duplicated word.
- Illegal fire: requester 1 pulses `ENA` while requester 0 holds the grant -> ignored; `last` and the data registers are unchanged.
- Stats (with `SAY_ARB_STATS_EN`): 70000 accepts from requester 0 -> `grant_count[15:0]` = 0xFFFF; requester 1's count = 0.

Source files
------------

// File: rtl/say_arbiter_pkg.sv
// Shared constants and types for the say-channel arbiter and its helpers.
package say_arbiter_pkg;

  localparam int SAY_DW           = 192;
  localparam int SAY_ARB_MAX_NREQ = 8;

  typedef struct packed {
    logic [SAY_DW-1:0] meth;
    logic [SAY_DW-1:0] v;
  } say_req_t;

endpackage

// File: rtl/say_arbiter_rr_pick.sv
// rr_pick: combinational cyclic priority encoder. Finds the first set want bit
// searching upward from last+1, wrapping at N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  want,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] sel,
  output logic          valid
);

  // Walk the cyclic order once; the first hit wins and later hits are ignored.
  always_comb begin
    logic [LW-1:0] idx_s;
    sel   = '0;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx_s = LW'((int'(last) + k) % N);
      if (!valid && want[idx_s]) begin
        sel   = idx_s;
        valid = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/say_arbiter.sv
// Round-robin arbiter sharing one say channel among NREQ requesters, with a
// one-entry output register. Optional per-requester counters: SAY_ARB_STATS_EN.
module say_arbiter
  import say_arbiter_pkg::*;
#(
  parameter int  NREQ = 4,
  parameter int  DW   = SAY_DW,
  localparam int LW   = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NREQ-1:0]   req_want,
  input  logic [NREQ-1:0]   req__ENA,
  input  logic [NREQ*DW-1:0] req_meth,
  input  logic [NREQ*DW-1:0] req_v,
  output logic [NREQ-1:0]   req_RDY,
  output logic              say__ENA,
  output logic [DW-1:0]     say_meth,
  output logic [DW-1:0]     say_v,
  input  logic              say__RDY,
  output logic [LW-1:0]     say_src
`ifdef SAY_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_count
`endif
);

  logic          full_r;
  logic [LW-1:0] last_r;
  logic [LW-1:0] sel_s;
  logic          valid_s;
  logic          can_accept_s;
  logic          accept_s;

  rr_pick #(.N(NREQ), .LW(LW)) u_rr_pick (
    .want  (req_want),
    .last  (last_r),
    .sel   (sel_s),
    .valid (valid_s)
  );

  // A draining register frees its slot in the same cycle, so say__RDY lets a new grant through.
  assign can_accept_s = !full_r || say__RDY;
  assign accept_s     = can_accept_s && valid_s && req__ENA[sel_s];
  assign say__ENA     = full_r && say__RDY;

  // Grant is one-hot on the selected requester, or zero when blocked or idle.
  always_comb begin
    req_RDY = '0;
    if (can_accept_s && valid_s) begin
      req_RDY[sel_s] = 1'b1;
    end else begin
      req_RDY = '0;
    end
  end

  // Output register, occupancy flag and round-robin pointer.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      full_r   <= 1'b0;
      last_r   <= LW'(NREQ - 1);
      say_meth <= '0;
      say_v    <= '0;
      say_src  <= '0;
    end else if (accept_s) begin
      full_r   <= 1'b1;
      last_r   <= sel_s;
      say_src  <= sel_s;
      say_meth <= req_meth[int'(sel_s)*DW +: DW];
      say_v    <= req_v[int'(sel_s)*DW +: DW];
    end else if (say__ENA) begin
      full_r   <= 1'b0;
    end
  end

`ifdef SAY_ARB_STATS_EN
  logic [15:0] cnt_r [NREQ];

  // Saturating accept counters; only reset clears them.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_r[i] <= 16'h0000;
      end
    end else if (accept_s && (cnt_r[sel_s] != 16'hFFFF)) begin
      cnt_r[sel_s] <= cnt_r[sel_s] + 16'h0001;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign grant_count[g*16 +: 16] = cnt_r[g];
  end
`endif

endmodule

// File: tb/tb_say_arbiter.sv
// Self-checking bench for say_arbiter: directed vector table, hand sequences and
// randomized traffic against a transaction-level reference model.
module tb_say_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 192;
  localparam int LW   = 2;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [NREQ-1:0]   req_want, req__ENA, req_RDY;
  logic [NREQ*DW-1:0] req_meth, req_v;
  logic              say__ENA, say__RDY;
  logic [DW-1:0]     say_meth, say_v;
  logic [LW-1:0]     say_src;
`ifdef SAY_ARB_STATS_EN
  logic [NREQ*16-1:0] grant_count;
  int                m_cnt [NREQ];
`endif

  say_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_want(req_want), .req__ENA(req__ENA),
    .req_meth(req_meth), .req_v(req_v), .req_RDY(req_RDY),
    .say__ENA(say__ENA), .say_meth(say_meth), .say_v(say_v),
    .say__RDY(say__RDY), .say_src(say_src)
`ifdef SAY_ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  always #5 CLK = ~CLK;

  int ntests = 0;
  int nfail  = 0;

  // reference model: one buffered word plus the last granted index
  bit              m_full;
  int              m_last;
  int              m_src;
  logic [DW-1:0]   m_meth, m_v;
  logic [NREQ-1:0] exp_rdy;
  bit              exp_ena;
  int              n_fire, n_drain;

  typedef struct {
    bit         rst;
    logic [3:0] want, ena;
    logic       rdy;
    logic [11:0] base;
    logic [3:0] e_rdy;
    logic       e_ena;
    logic [1:0] e_src;
    logic [11:0] e_meth;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_data(input logic [11:0] base);
    for (int i = 0; i < NREQ; i++) begin
      req_meth[i*DW +: DW] = DW'(base) + DW'(i);
      req_v[i*DW +: DW]    = ~(DW'(base) + DW'(i));
    end
  endtask

  task automatic apply(input logic [3:0] w, input logic [3:0] e, input logic r);
    req_want = w; req__ENA = e; say__RDY = r;
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; req_want = '0; req__ENA = '0; say__RDY = 1'b0;
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;
    m_full = 1'b0; m_last = NREQ - 1; m_src = 0; m_meth = '0; m_v = '0;
`ifdef SAY_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
`endif
  endtask

  // Grant = first wanting requester in the rotation after the previous winner.
  task automatic model_eval();
    exp_rdy = '0;
    if (!m_full || say__RDY) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx = (m_last + k) % NREQ;
        if (req_want[idx] && exp_rdy == '0) exp_rdy[idx] = 1'b1;
      end
    end
    exp_ena = m_full && say__RDY;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " req_RDY"}, req_RDY, exp_rdy);
    chk({tag, " say__ENA"}, say__ENA, exp_ena);
    chk({tag, " say_meth"}, say_meth, m_meth);
    chk({tag, " say_v"}, say_v, m_v);
    chk({tag, " say_src"}, say_src, m_src);
`ifdef SAY_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk({tag, " grant_count"}, grant_count[i*16 +: 16], m_cnt[i]);
`endif
  endtask

  task automatic advance();
    int acc = -1;
    for (int i = 0; i < NREQ; i++) if (exp_rdy[i] && req__ENA[i]) acc = i;
    if (exp_ena) n_drain++;
    if (acc >= 0) begin
      n_fire++;
      m_full = 1'b1; m_last = acc; m_src = acc;
      m_meth = req_meth[acc*DW +: DW];
      m_v    = req_v[acc*DW +: DW];
`ifdef SAY_ARB_STATS_EN
      if (m_cnt[acc] < 65535) m_cnt[acc]++;
`endif
    end else if (exp_ena) begin
      m_full = 1'b0;
    end
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0; req_want = '0; req__ENA = '0; say__RDY = 1'b0;
    req_meth = '0; req_v = '0;
    // contention: all want and fire, grant order 0,1,2,3,0 with say_src one cycle behind
    tbl[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 12'h001, 4'b0001, 1'b0, 2'd0, 12'h000};
    tbl[1]  = '{1'b0, 4'hF, 4'hF, 1'b1, 12'h001, 4'b0010, 1'b1, 2'd0, 12'h001};
    tbl[2]  = '{1'b0, 4'hF, 4'hF, 1'b1, 12'h001, 4'b0100, 1'b1, 2'd1, 12'h002};
    tbl[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 12'h001, 4'b1000, 1'b1, 2'd2, 12'h003};
    tbl[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 12'h001, 4'b0001, 1'b1, 2'd3, 12'h004};
    tbl[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 12'h001, 4'b0010, 1'b1, 2'd0, 12'h001};
    // backpressure: requester 2 sends 0xABC into a stalled register (reset drops the buffered word)
    tbl[6]  = '{1'b1, 4'b0100, 4'b0100, 1'b0, 12'hABA, 4'b0100, 1'b0, 2'd0, 12'h000};
    tbl[7]  = '{1'b0, 4'b1100, 4'b0000, 1'b0, 12'hABA, 4'b0000, 1'b0, 2'd2, 12'hABC};
    tbl[8]  = '{1'b0, 4'b1100, 4'b0000, 1'b0, 12'hABA, 4'b0000, 1'b0, 2'd2, 12'hABC};
    tbl[9]  = '{1'b0, 4'b1100, 4'b0000, 1'b0, 12'hABA, 4'b0000, 1'b0, 2'd2, 12'hABC};
    tbl[10] = '{1'b0, 4'b1100, 4'b0000, 1'b0, 12'hABA, 4'b0000, 1'b0, 2'd2, 12'hABC};
    tbl[11] = '{1'b0, 4'b1100, 4'b0000, 1'b0, 12'hABA, 4'b0000, 1'b0, 2'd2, 12'hABC};
    tbl[12] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 12'hABA, 4'b1000, 1'b1, 2'd2, 12'hABC};
    tbl[13] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 12'hABA, 4'b0000, 1'b1, 2'd3, 12'hABD};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 12'hABA, 4'b0000, 1'b0, 2'd3, 12'hABD};
    // illegal fire from 1 while 0 holds the grant; pointer must still be 3
    tbl[15] = '{1'b1, 4'b0001, 4'b0010, 1'b1, 12'h001, 4'b0001, 1'b0, 2'd0, 12'h000};
    tbl[16] = '{1'b0, 4'b0110, 4'b0000, 1'b1, 12'h001, 4'b0010, 1'b0, 2'd0, 12'h000};

    // reset then idle
    do_reset();
    set_data(12'h5A5);
    for (int c = 0; c < 10; c++) begin
      apply(4'h0, 4'h0, 1'b1);
      model_eval();
      chk("idle req_RDY", req_RDY, 4'h0);
      chk("idle say__ENA", say__ENA, 1'b0);
      chk("idle say_meth", say_meth, '0);
      advance();
    end

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rst) do_reset();
      set_data(tbl[i].base);
      apply(tbl[i].want, tbl[i].ena, tbl[i].rdy);
      model_eval();
      chk($sformatf("v%0d req_RDY", i), req_RDY, tbl[i].e_rdy);
      chk($sformatf("v%0d say__ENA", i), say__ENA, tbl[i].e_ena);
      chk($sformatf("v%0d say_src", i), say_src, tbl[i].e_src);
      chk($sformatf("v%0d say_meth", i), say_meth, tbl[i].e_meth);
      check_model($sformatf("v%0d model", i));
      advance();
    end

    // randomized traffic, including back-to-back fires and illegal strobes
    do_reset();
    n_fire = 0; n_drain = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] w, e;
      for (int i = 0; i < NREQ; i++) begin
        req_meth[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_v[i*DW +: DW]    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      w = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 3) != 0) ? w : 4'($urandom_range(0, 15));
      apply(w, e, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      model_eval();
      check_model("rand");
      advance();
    end
    for (int c = 0; c < 2; c++) begin
      apply(4'h0, 4'h0, 1'b1);
      model_eval();
      check_model("flush");
      advance();
    end
    chk("fire_vs_drain", DW'(n_drain), DW'(n_fire));

`ifdef SAY_ARB_STATS_EN
    do_reset();
    set_data(12'h001);
    for (int c = 0; c < 70000; c++) begin
      apply(4'b0001, 4'b0001, 1'b1);
      model_eval();
      advance();
    end
    apply(4'h0, 4'h0, 1'b1);
    model_eval();
    chk("stats sat req0", grant_count[15:0], 16'hFFFF);
    chk("stats req1", grant_count[31:16], 16'h0000);
    check_model("stats");
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
